bpu_repair_queue: RTL and testbench

- Buffers branch-predictor repair requests produced by the IF-stage fix selector (front-end and back-end repair merged into one stream) and replays them to the predictor tables' shared update port.
- Sits between the fix selector and the BTB/PHT/IJTC write port. Lookups have priority on that port, so repairs must wait without loss of order.
- Repairs are non-architectural hints: overflow drops the request and counts it, never stalls the fetch pipeline.

---
 rtl/bpu_repair_queue.sv | 153 +++++++++++++++
 tb/tb_bpu_repair_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_repair_queue.sv
// -----------------------------------------------------------------------------
// bpu_repair_queue
//
// Buffers branch-predictor repair requests coming from the IF-stage fix
// selector and replays them, in strict FIFO order, to the shared update port
// of the BTB/PHT/IJTC tables. Lookups own that port, so a repair waits at the
// head until BPU_ready_i is seen. Repairs are only hints: when the queue is
// full, a new request is dropped and counted, and fetch is never stalled.
//
// Optional feature (compile-time macro BRQ_MERGE_EN):
//   When defined, a request whose PC matches the youngest queued entry
//   overwrites that entry in place instead of pushing. The merge is skipped
//   when the queue is empty, and when the youngest entry is the head that is
//   being popped this cycle. A merge into a full queue is not a drop.
//   When undefined, every valid request takes the normal push/drop path.
//
// Ports:
//   clk, rst             single rising-edge clock, async active-high reset
//   FU_valid_w_i         repair request present this cycle
//   FU_repairAction_w_i  repair action (ACT_W bits)
//   FU_erroVAddr_w_i     mispredicted branch PC
//   FU_correctTake_w_i   correct direction
//   FU_correctDest_w_i   correct target
//   BRQ_valid_o          head entry available (occupancy != 0)
//   BPU_ready_i          predictor update port free; pops the head if valid
//   BRQ_repairAction_o   head action
//   BRQ_erroVAddr_o      head PC
//   BRQ_correctTake_o    head direction
//   BRQ_correctDest_o    head target
//   BRQ_full_o           occupancy == DEPTH
//   BRQ_dropCnt_o        saturating count of dropped requests (CNT_W bits)
// -----------------------------------------------------------------------------
module bpu_repair_queue #(
    parameter int DEPTH = 4,
    parameter int ACT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             FU_valid_w_i,
    input  logic [ACT_W-1:0] FU_repairAction_w_i,
    input  logic [31:0]      FU_erroVAddr_w_i,
    input  logic             FU_correctTake_w_i,
    input  logic [31:0]      FU_correctDest_w_i,
    output logic             BRQ_valid_o,
    input  logic             BPU_ready_i,
    output logic [ACT_W-1:0] BRQ_repairAction_o,
    output logic [31:0]      BRQ_erroVAddr_o,
    output logic             BRQ_correctTake_o,
    output logic [31:0]      BRQ_correctDest_o,
    output logic             BRQ_full_o,
    output logic [CNT_W-1:0] BRQ_dropCnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Entry storage; data is never reset, only the control state below.
    logic [ACT_W-1:0] act_mem  [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             take_mem [DEPTH];
    logic [31:0]      dest_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   occ;
    logic [CNT_W-1:0] drop_cnt;

    logic             valid;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             merge_hit;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign valid = (occ != '0);
    assign full  = (occ == OCC_FULL);
    assign pop   = valid && BPU_ready_i;

`ifdef BRQ_MERGE_EN
    logic [PTR_W-1:0] young_idx;

    assign young_idx = wr_ptr - PTR_ONE;
    // With a single entry being popped, the youngest entry is leaving this
    // cycle, so rewriting it would lose the request; push normally instead.
    assign merge_hit = FU_valid_w_i && valid
                    && (pc_mem[young_idx] == FU_erroVAddr_w_i)
                    && !(pop && (occ == OCC_ONE));
    assign wr_idx    = merge_hit ? young_idx : wr_ptr;
`else
    assign merge_hit = 1'b0;
    assign wr_idx    = wr_ptr;
`endif

    // A full queue still accepts a push when the head leaves the same cycle.
    assign push  = FU_valid_w_i && !merge_hit && (!full || pop);
    assign drop  = FU_valid_w_i && !merge_hit && full && !pop;
    assign wr_en = push || merge_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                occ <= occ + OCC_ONE;
            end else if (pop && !push) begin
                occ <= occ - OCC_ONE;
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            act_mem[wr_idx]  <= FU_repairAction_w_i;
            pc_mem[wr_idx]   <= FU_erroVAddr_w_i;
            take_mem[wr_idx] <= FU_correctTake_w_i;
            dest_mem[wr_idx] <= FU_correctDest_w_i;
        end
    end

    // First-word-fall-through: the head entry is visible without a read strobe.
    assign BRQ_valid_o        = valid;
    assign BRQ_full_o         = full;
    assign BRQ_dropCnt_o      = drop_cnt;
    assign BRQ_repairAction_o = act_mem[rd_ptr];
    assign BRQ_erroVAddr_o    = pc_mem[rd_ptr];
    assign BRQ_correctTake_o  = take_mem[rd_ptr];
    assign BRQ_correctDest_o  = dest_mem[rd_ptr];

endmodule

// File: tb/tb_bpu_repair_queue.sv
module tb_bpu_repair_queue;

    localparam int ACT_W = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fu_valid = 1'b0;
    logic [ACT_W-1:0] fu_act = '0;
    logic [31:0]      fu_pc = '0;
    logic             fu_take = 1'b0;
    logic [31:0]      fu_dest = '0;
    logic             bpu_ready = 1'b0;
    logic             q_valid;
    logic [ACT_W-1:0] q_act;
    logic [31:0]      q_pc;
    logic             q_take;
    logic [31:0]      q_dest;
    logic             q_full;
    logic [CNT_W-1:0] q_cnt;

    int compared = 0;
    int mismatched = 0;

    bpu_repair_queue #(.DEPTH(4), .ACT_W(ACT_W), .CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .FU_valid_w_i        (fu_valid),
        .FU_repairAction_w_i (fu_act),
        .FU_erroVAddr_w_i    (fu_pc),
        .FU_correctTake_w_i  (fu_take),
        .FU_correctDest_w_i  (fu_dest),
        .BRQ_valid_o         (q_valid),
        .BPU_ready_i         (bpu_ready),
        .BRQ_repairAction_o  (q_act),
        .BRQ_erroVAddr_o     (q_pc),
        .BRQ_correctTake_o   (q_take),
        .BRQ_correctDest_o   (q_dest),
        .BRQ_full_o          (q_full),
        .BRQ_dropCnt_o       (q_cnt)
    );

    always #5 clk = ~clk;

    // Side fields are derived from the PC so each entry is distinguishable.
    function automatic logic [31:0] f_dest(input logic [31:0] pc);
        return pc ^ 32'h0000_0300;
    endfunction
    function automatic logic f_take(input logic [31:0] pc);
        return pc[8] ^ pc[4];
    endfunction
    function automatic logic [ACT_W-1:0] f_act(input logic [31:0] pc);
        return pc[7:4] ^ pc[11:8];
    endfunction

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        rdy;
        logic        ev;
        logic        ef;
        logic [7:0]  ecnt;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fv, input logic [31:0] pc, input logic rdy,
                                input logic ev, input logic ef, input logic [7:0] ecnt,
                                input logic [31:0] epc);
        vec_t v;
        v.fv = fv; v.pc = pc; v.rdy = rdy;
        v.ev = ev; v.ef = ef; v.ecnt = ecnt; v.epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] dest,
                         input logic rdy);
        fu_valid  = fv;
        fu_pc     = pc;
        fu_dest   = dest;
        fu_take   = f_take(pc);
        fu_act    = f_act(pc);
        bpu_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic [31:0] epc,
                              input logic [31:0] edest);
        check({name, ".valid"}, 64'(q_valid), 64'(1'b1));
        check({name, ".pc"},    64'(q_pc),    64'(epc));
        check({name, ".dest"},  64'(q_dest),  64'(edest));
        check({name, ".take"},  64'(q_take),  64'(f_take(epc)));
        check({name, ".act"},   64'(q_act),   64'(f_act(epc)));
    endtask

    logic [7:0] cnt_model;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", 64'(q_valid), 64'(1'b0));
        check("reset.full",  64'(q_full),  64'(1'b0));
        check("reset.cnt",   64'(q_cnt),   64'(0));
        rst = 1'b0;
        step();

        // Single push/pop, 4-deep fill with drop, full push+pop, drain,
        // and simultaneous push/pop at occupancy 1.
        vecs.push_back(mk(1, 32'h8000_0100, 0, 1, 0, 0, 32'h8000_0100));
        vecs.push_back(mk(0, 32'h0,         0, 1, 0, 0, 32'h8000_0100));
        vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,         1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 32'h10,        0, 1, 0, 0, 32'h10));
        vecs.push_back(mk(1, 32'h20,        0, 1, 0, 0, 32'h10));
        vecs.push_back(mk(1, 32'h30,        0, 1, 0, 0, 32'h10));
        vecs.push_back(mk(1, 32'h40,        0, 1, 1, 0, 32'h10));
        vecs.push_back(mk(1, 32'h50,        0, 1, 1, 1, 32'h10));
        vecs.push_back(mk(0, 32'h0,         0, 1, 1, 1, 32'h10));
        vecs.push_back(mk(1, 32'h60,        1, 1, 1, 1, 32'h20));
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 1, 32'h30));
        vecs.push_back(mk(0, 32'h0,         0, 1, 0, 1, 32'h30));
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 1, 32'h40));
        vecs.push_back(mk(0, 32'h0,         1, 1, 0, 1, 32'h60));
        vecs.push_back(mk(0, 32'h0,         1, 0, 0, 1, 32'h0));
        vecs.push_back(mk(1, 32'h70,        0, 1, 0, 1, 32'h70));
        vecs.push_back(mk(1, 32'h80,        1, 1, 0, 1, 32'h80));
        vecs.push_back(mk(0, 32'h0,         1, 0, 0, 1, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vecs[i].fv, vecs[i].pc, f_dest(vecs[i].pc), vecs[i].rdy);
            step();
            check({nm, ".valid"}, 64'(q_valid), 64'(vecs[i].ev));
            check({nm, ".full"},  64'(q_full),  64'(vecs[i].ef));
            check({nm, ".cnt"},   64'(q_cnt),   64'(vecs[i].ecnt));
            if (vecs[i].ev) begin
                check({nm, ".pc"},   64'(q_pc),   64'(vecs[i].epc));
                check({nm, ".dest"}, 64'(q_dest), 64'(f_dest(vecs[i].epc)));
                check({nm, ".take"}, 64'(q_take), 64'(f_take(vecs[i].epc)));
                check({nm, ".act"},  64'(q_act),  64'(f_act(vecs[i].epc)));
            end
        end

        // Drop counter saturation: fill, then 300 pushes into a full queue.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000 + 32'(i) * 32'h10, f_dest(32'h1000 + 32'(i) * 32'h10), 0);
            step();
        end
        check("sat.full", 64'(q_full), 64'(1'b1));
        cnt_model = 8'd1;
        for (int i = 0; i < 300; i++) begin
            drive(1, 32'h2000 + 32'(i) * 32'h10, 32'h0, 0);
            step();
            if (cnt_model != 8'hFF) cnt_model = cnt_model + 8'd1;
            if (i >= 251 && i <= 255)
                check($sformatf("sat.cnt%0d", i), 64'(q_cnt), 64'(cnt_model));
        end
        check("sat.final", 64'(q_cnt), 64'(8'd255));
        check_head("sat.head", 32'h1000, f_dest(32'h1000));

        // Asynchronous reset between edges clears everything at once.
        drive(0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst1.valid", 64'(q_valid), 64'(1'b0));
        check("arst1.full",  64'(q_full),  64'(1'b0));
        check("arst1.cnt",   64'(q_cnt),   64'(0));
        step();
        rst = 1'b0;
        drive(1, 32'h900, f_dest(32'h900), 0);
        step();
        drive(1, 32'h910, f_dest(32'h910), 0);
        step();
        check_head("two.head", 32'h900, f_dest(32'h900));
        drive(0, 32'h0, 32'h0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst2.valid", 64'(q_valid), 64'(1'b0));
        check("arst2.full",  64'(q_full),  64'(1'b0));
        step();
        rst = 1'b0;
        drive(1, 32'hA00, f_dest(32'hA00), 0);
        step();
        check_head("post_rst.head", 32'hA00, f_dest(32'hA00));
        drive(0, 32'h0, 32'h0, 1);
        step();
        check("post_rst.empty", 64'(q_valid), 64'(1'b0));

        // Same PC pushed twice back to back.
        drive(1, 32'h100, 32'hA00, 0);
        step();
        drive(1, 32'h100, 32'hB00, 0);
        step();
        drive(0, 32'h0, 32'h0, 0);
`ifdef BRQ_MERGE_EN
        check_head("merge.head", 32'h100, 32'hB00);
        drive(0, 32'h0, 32'h0, 1);
        step();
        check("merge.empty", 64'(q_valid), 64'(1'b0));
        // Merge into a full queue is not counted as a drop.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h300 + 32'(i) * 32'h10, f_dest(32'h300 + 32'(i) * 32'h10), 0);
            step();
        end
        drive(1, 32'h330, 32'h0, 0);
        step();
        check("merge_full.full", 64'(q_full), 64'(1'b1));
        check("merge_full.cnt",  64'(q_cnt),  64'(0));
`else
        check_head("nomerge.head0", 32'h100, 32'hA00);
        drive(0, 32'h0, 32'h0, 1);
        step();
        check_head("nomerge.head1", 32'h100, 32'hB00);
        step();
        check("nomerge.empty", 64'(q_valid), 64'(1'b0));
`endif
        drive(0, 32'h0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
